ppr_walk_engine: RTL and testbench

//  Synthesizable, parametrised random-walk engine for PPR. It is the successor to the testbench-style walker.
//  For each seed accepted on a valid/ready stream, it runs WALKS_PER_SEED walks of up to MAX_STEPS hops.
//  The graph is a CSR held in an external single-port BRAM (bram, 1-cycle read latency).

---
 rtl/rw_pkg.sv | 28 ++
 rtl/rw_lfsr.sv | 30 +++
 rtl/ppr_walk_engine.sv | 190 +++++++++++++++++++
 tb/tb_ppr_walk_engine.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rw_pkg.sv
// Shared types and helpers for the PPR random-walk engine.
package rw_pkg;

    typedef enum logic [3:0] {
        IDLE,
        P0,
        P1,
        PICK,
        NEI,
        CNT,
        INC,
        WR,
        END_WALK
    } rw_state_e;

    localparam int unsigned HOP_CYCLES = 7;

    // Right-shift Galois toggle mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [63:0] cnt_addr(input logic [63:0] base,
                                             input logic [63:0] node,
                                             input logic [63:0] steps,
                                             input logic [63:0] step);
        return base + node * steps + step;
    endfunction

endpackage

// File: rtl/rw_lfsr.sv
// Galois LFSR that free-runs every clock and exposes its low bits as a random value.
module rw_lfsr #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  SEED      = '1,
    parameter logic [WIDTH-1:0]  TAPS      = '1,
    parameter int unsigned       OUT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output logic [OUT_WIDTH-1:0] o_value
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_value = lfsr_q[OUT_WIDTH-1:0];

endmodule

// File: rtl/ppr_walk_engine.sv
// PPR random-walk engine: per seed, runs WALKS_PER_SEED walks over a CSR graph in BRAM
// and increments a saturating per-(node,step) visit counter on every hop.
module ppr_walk_engine
    import rw_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NODE_NUM       = 100,
    parameter int unsigned MAX_STEPS      = 7,
    parameter int unsigned WALKS_PER_SEED = 100,
    parameter int unsigned ROW_PTR_BASE   = 10,
    parameter int unsigned COL_BASE       = 120,
    parameter int unsigned COUNT_BASE     = 1000,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_1234
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_seed_valid,
    input  logic [DATA_WIDTH-1:0] i_seed_node,
    input  logic                  i_seed_last,
    output logic                  o_seed_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic [31:0]           o_walk_count,
    output logic [31:0]           o_dead_ends
);

    localparam int unsigned SW = $clog2(MAX_STEPS + 1);
    localparam int unsigned WW = $clog2(WALKS_PER_SEED + 1);

    rw_state_e             state_q;
    logic [DATA_WIDTH-1:0] seed_q, cur_q, first_q, nxt_q;
    logic                  last_q;
    logic [SW-1:0]         step_q;
    logic [WW-1:0]         walk_q;
    logic                  ready_q, busy_q, done_q, we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [31:0]           walk_cnt_q, dead_cnt_q;

    logic [15:0]           lfsr_lo;
    logic [DATA_WIDTH-1:0] deg;
    logic [15:0]           off;

    rw_lfsr #(
        .WIDTH    (32),
        .SEED     (LFSR_SEED),
        .TAPS     (LFSR_TAPS),
        .OUT_WIDTH(16)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .o_value(lfsr_lo)
    );

    function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [DATA_WIDTH-1:0] node,
                                                       input logic inc);
        return ADDR_WIDTH'(DATA_WIDTH'(ROW_PTR_BASE) + node + DATA_WIDTH'(inc));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] ctr_addr(input logic [DATA_WIDTH-1:0] node,
                                                       input logic [SW-1:0] step);
        return ADDR_WIDTH'(DATA_WIDTH'(cnt_addr(64'(COUNT_BASE), 64'(node),
                                                64'(MAX_STEPS), 64'(step))));
    endfunction

    // Neighbour offset scales the random value into [0,deg) without a divider.
    always_comb begin
        deg = i_mem_rdata - first_q;
        off = 16'(({16'h0, lfsr_lo} * {16'h0, deg[15:0]}) >> 16);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            seed_q     <= '0;
            cur_q      <= '0;
            first_q    <= '0;
            nxt_q      <= '0;
            last_q     <= 1'b0;
            step_q     <= '0;
            walk_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            walk_cnt_q <= '0;
            dead_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (i_seed_valid && ready_q) begin
                        if (i_seed_node >= DATA_WIDTH'(NODE_NUM)) begin
                            done_q <= i_seed_last;
                        end else begin
                            seed_q  <= i_seed_node;
                            cur_q   <= i_seed_node;
                            last_q  <= i_seed_last;
                            step_q  <= '0;
                            walk_q  <= '0;
                            addr_q  <= row_addr(i_seed_node, 1'b0);
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= P0;
                        end
                    end
                end
                P0: begin
                    addr_q  <= row_addr(cur_q, 1'b1);
                    state_q <= P1;
                end
                P1: begin
                    first_q <= i_mem_rdata;
                    state_q <= PICK;
                end
                PICK: begin
                    if (deg == '0) begin
                        dead_cnt_q <= dead_cnt_q + 32'd1;
                        state_q    <= END_WALK;
                    end else begin
                        addr_q  <= ADDR_WIDTH'(DATA_WIDTH'(COL_BASE) + first_q + DATA_WIDTH'(off));
                        state_q <= NEI;
                    end
                end
                NEI: state_q <= CNT;
                CNT: begin
                    nxt_q <= i_mem_rdata;
                    if (i_mem_rdata >= DATA_WIDTH'(NODE_NUM)) begin
                        dead_cnt_q <= dead_cnt_q + 32'd1;
                        state_q    <= END_WALK;
                    end else begin
                        addr_q  <= ctr_addr(i_mem_rdata, step_q);
                        state_q <= INC;
                    end
                end
                INC: begin
                    wdata_q <= (i_mem_rdata == '1) ? '1 : i_mem_rdata + DATA_WIDTH'(1);
                    we_q    <= 1'b1;
                    state_q <= WR;
                end
                WR: begin
                    cur_q  <= nxt_q;
                    step_q <= step_q + SW'(1);
                    if (step_q == SW'(MAX_STEPS - 1)) begin
                        state_q <= END_WALK;
                    end else begin
                        addr_q  <= row_addr(nxt_q, 1'b0);
                        state_q <= P0;
                    end
                end
                END_WALK: begin
                    walk_cnt_q <= walk_cnt_q + 32'd1;
                    cur_q      <= seed_q;
                    step_q     <= '0;
                    if (walk_q == WW'(WALKS_PER_SEED - 1)) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= last_q;
                        state_q <= IDLE;
                    end else begin
                        walk_q  <= walk_q + WW'(1);
                        addr_q  <= row_addr(seed_q, 1'b0);
                        state_q <= P0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The counter address depends on the col_idx word arriving this cycle, so CNT bypasses addr_q.
    assign o_mem_addr   = (state_q == CNT) ? ctr_addr(i_mem_rdata, step_q) : addr_q;
    assign o_seed_ready = ready_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_mem_we     = we_q;
    assign o_mem_wdata  = wdata_q;
    assign o_walk_count = walk_cnt_q;
    assign o_dead_ends  = dead_cnt_q;

endmodule

// File: tb/tb_ppr_walk_engine.sv
// Directed bench: instance A (MAX_STEPS=3, WALKS=4) on a 3-node ring, instance B (MAX_STEPS=1, WALKS=1000) on a star.
module tb_ppr_walk_engine;
    import rw_pkg::*;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;
    localparam int unsigned A_STEPS = 3;
    localparam int unsigned A_WALKS = 4;
    localparam int unsigned B_STEPS = 1;
    localparam int unsigned B_WALKS = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a_n, rst_b_n;
    logic          valid_a, last_a, ready_a, busy_a, done_a, we_a;
    logic          valid_b, last_b, ready_b, busy_b, done_b, we_b;
    logic [DW-1:0] node_a, wdata_a, rdata_a, node_b, wdata_b, rdata_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [31:0]   walks_a, dead_a, walks_b, dead_b;

    logic [DW-1:0] mem_a [0:8191];
    logic [DW-1:0] mem_b [0:8191];
    logic          ld_we_a, ld_we_b;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    int checks, fails;
    int done_cnt_a, wr_cnt_a, rdy_busy_a;

    ppr_walk_engine #(.MAX_STEPS(A_STEPS), .WALKS_PER_SEED(A_WALKS)) dut_a (
        .i_clk(clk), .i_rst_n(rst_a_n), .i_seed_valid(valid_a), .i_seed_node(node_a),
        .i_seed_last(last_a), .o_seed_ready(ready_a), .o_busy(busy_a), .o_done(done_a),
        .o_mem_addr(addr_a), .o_mem_we(we_a), .o_mem_wdata(wdata_a), .i_mem_rdata(rdata_a),
        .o_walk_count(walks_a), .o_dead_ends(dead_a)
    );

    ppr_walk_engine #(.MAX_STEPS(B_STEPS), .WALKS_PER_SEED(B_WALKS)) dut_b (
        .i_clk(clk), .i_rst_n(rst_b_n), .i_seed_valid(valid_b), .i_seed_node(node_b),
        .i_seed_last(last_b), .o_seed_ready(ready_b), .o_busy(busy_b), .o_done(done_b),
        .o_mem_addr(addr_b), .o_mem_we(we_b), .o_mem_wdata(wdata_b), .i_mem_rdata(rdata_b),
        .o_walk_count(walks_b), .o_dead_ends(dead_b)
    );

    // Single-port read-first BRAMs with a bench-side load port.
    always @(posedge clk) begin
        if (ld_we_a) mem_a[ld_addr] <= ld_data;
        else if (we_a) mem_a[addr_a] <= wdata_a;
        rdata_a <= mem_a[addr_a];
        if (ld_we_b) mem_b[ld_addr] <= ld_data;
        else if (we_b) mem_b[addr_b] <= wdata_b;
        rdata_b <= mem_b[addr_b];
    end

    always @(negedge clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (we_a === 1'b1) wr_cnt_a++;
        if (ready_a === 1'b1 && busy_a === 1'b1) rdy_busy_a++;
    end

    task automatic ld(input bit sel, input int unsigned addr, input logic [31:0] data);
        ld_addr = AW'(addr);
        ld_data = data;
        if (sel) ld_we_b = 1'b1; else ld_we_a = 1'b1;
        @(posedge clk); #1;
        ld_we_a = 1'b0;
        ld_we_b = 1'b0;
    endtask

    task automatic zero_counters(input bit sel);
        int unsigned n;
        n = sel ? 100 * B_STEPS : 100 * A_STEPS;
        for (int unsigned i = 0; i < n; i++) ld(sel, 1000 + i, 32'd0);
    endtask

    // Cycle 1 is the handshake cycle; cyc returns the cycle in which o_done (or ready) is seen.
    task automatic run_seed(input bit sel, input logic [31:0] node, input bit last, output int cyc);
        int n;
        n = 0;
        while (!(sel ? ready_b : ready_a) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; fails++;
            $display("FAIL ready_wait: ready stayed 0, required 1 within 100 cycles");
        end
        if (sel) begin valid_b = 1'b1; node_b = node; last_b = last; end
        else     begin valid_a = 1'b1; node_a = node; last_a = last; end
        @(posedge clk); #1;
        valid_a = 1'b0; last_a = 1'b0; valid_b = 1'b0; last_b = 1'b0;
        cyc = 2;
        while (!(last ? (sel ? done_b : done_a) : (sel ? ready_b : ready_a))) begin
            if (cyc >= 20000) break;
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= 20000) begin
            checks++; fails++;
            $display("FAIL seed_timeout: no completion after %0d cycles, required completion", cyc);
        end
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({ready_a, busy_a, done_a, we_a, ready_b, busy_b, done_b, we_b} !== 8'h00) begin
            fails++; $display("FAIL reset_flags: got %b required 00000000",
                              {ready_a, busy_a, done_a, we_a, ready_b, busy_b, done_b, we_b});
        end
        checks++;
        if (addr_a !== '0 || wdata_a !== '0 || addr_b !== '0 || wdata_b !== '0) begin
            fails++; $display("FAIL reset_mem_port: addr_a=%0d wdata_a=%0d addr_b=%0d wdata_b=%0d required 0",
                              addr_a, wdata_a, addr_b, wdata_b);
        end
        checks++;
        if (walks_a !== 0 || dead_a !== 0 || walks_b !== 0 || dead_b !== 0) begin
            fails++; $display("FAIL reset_counts: walks_a=%0d dead_a=%0d walks_b=%0d dead_b=%0d required 0",
                              walks_a, dead_a, walks_b, dead_b);
        end
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready_a !== 1'b1 || busy_a !== 1'b0) begin
            fails++; $display("FAIL ready_after_reset: ready=%b busy=%b required 1 0", ready_a, busy_a);
        end
    endtask

    task automatic load_graphs();
        for (int unsigned n = 0; n <= 100; n++) ld(1'b0, 10 + n, (n < 3) ? n : 3);
        ld(1'b0, 120, 32'd1);
        ld(1'b0, 121, 32'd2);
        ld(1'b0, 122, 32'd0);
        for (int unsigned n = 0; n <= 100; n++) ld(1'b1, 10 + n, (n == 0) ? 0 : 4);
        for (int unsigned k = 0; k < 4; k++) ld(1'b1, 120 + k, k + 1);
        zero_counters(1'b1);
    endtask

    task automatic check_ring(input string tag);
        // counter[n][s] at 1000 + 3n + s: [1][0]=1003, [2][1]=1007, [0][2]=1002
        checks++;
        if (mem_a[1003] !== 32'd4 || mem_a[1007] !== 32'd4 || mem_a[1002] !== 32'd4) begin
            fails++; $display("FAIL %s_counters: [1][0]=%0d [2][1]=%0d [0][2]=%0d required 4 4 4",
                              tag, mem_a[1003], mem_a[1007], mem_a[1002]);
        end
    endtask

    task automatic test_ring();
        int cyc, w0, d0, wr0;
        zero_counters(1'b0);
        w0 = walks_a; d0 = dead_a; wr0 = wr_cnt_a;
        run_seed(1'b0, 32'd0, 1'b1, cyc);
        checks++;
        if (cyc != int'(A_WALKS * (A_STEPS * HOP_CYCLES + 1) + 2)) begin
            fails++; $display("FAIL ring_done_cycle: got %0d required %0d", cyc,
                              A_WALKS * (A_STEPS * HOP_CYCLES + 1) + 2);
        end
        check_ring("ring");
        checks++;
        if (int'(walks_a) - w0 != 4 || int'(dead_a) - d0 != 0 || wr_cnt_a - wr0 != 12) begin
            fails++; $display("FAIL ring_stats: walks+%0d dead+%0d writes+%0d required 4 0 12",
                              int'(walks_a) - w0, int'(dead_a) - d0, wr_cnt_a - wr0);
        end
    endtask

    task automatic test_dead_end();
        int cyc, w0, d0, wr0;
        w0 = walks_a; d0 = dead_a; wr0 = wr_cnt_a;
        run_seed(1'b0, 32'd5, 1'b1, cyc);
        checks++;
        if (int'(dead_a) - d0 != 4 || int'(walks_a) - w0 != 4) begin
            fails++; $display("FAIL dead_end_counts: dead+%0d walks+%0d required 4 4",
                              int'(dead_a) - d0, int'(walks_a) - w0);
        end
        checks++;
        if (wr_cnt_a - wr0 != 0) begin
            fails++; $display("FAIL dead_end_writes: got %0d required 0", wr_cnt_a - wr0);
        end
    endtask

    task automatic test_saturation();
        int cyc;
        zero_counters(1'b0);
        ld(1'b0, 1003, 32'hFFFF_FFFF);
        run_seed(1'b0, 32'd0, 1'b1, cyc);
        checks++;
        if (mem_a[1003] !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL saturation: got %h required ffffffff", mem_a[1003]);
        end
        checks++;
        if (mem_a[1007] !== 32'd4 || mem_a[1002] !== 32'd4) begin
            fails++; $display("FAIL saturation_others: [2][1]=%0d [0][2]=%0d required 4 4",
                              mem_a[1007], mem_a[1002]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        zero_counters(1'b0);
        valid_a = 1'b1; node_a = 32'd0; last_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0; last_a = 1'b0;
        repeat (12) @(posedge clk); #1;
        // Cycle 14 is INC of hop 2, reading counter[2][1].
        checks++;
        if (addr_a !== AW'(1007) || we_a !== 1'b0) begin
            fails++; $display("FAIL mid_inc_addr: addr=%0d we=%b required 1007 0", addr_a, we_a);
        end
        rst_a_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ready_a, busy_a, done_a, we_a} !== 4'b0 || addr_a !== '0 || wdata_a !== '0
            || walks_a !== 0 || dead_a !== 0) begin
            fails++; $display("FAIL mid_reset_outputs: flags=%b addr=%0d wdata=%0d walks=%0d dead=%0d required 0",
                              {ready_a, busy_a, done_a, we_a}, addr_a, wdata_a, walks_a, dead_a);
        end
        checks++;
        if (mem_a[1003] !== 32'd1 || mem_a[1007] !== 32'd0) begin
            fails++; $display("FAIL mid_reset_mem: [1][0]=%0d [2][1]=%0d required 1 0",
                              mem_a[1003], mem_a[1007]);
        end
        rst_a_n = 1'b1;
        @(posedge clk); #1;
        zero_counters(1'b0);
        run_seed(1'b0, 32'd0, 1'b1, cyc);
        checks++;
        if (cyc != int'(A_WALKS * (A_STEPS * HOP_CYCLES + 1) + 2) || walks_a !== 32'd4) begin
            fails++; $display("FAIL rerun: cycle=%0d walks=%0d required %0d 4", cyc, walks_a,
                              A_WALKS * (A_STEPS * HOP_CYCLES + 1) + 2);
        end
        check_ring("rerun");
    endtask

    task automatic test_seed_stream();
        int cyc, w0, dn0, rb0, wr0;
        zero_counters(1'b0);
        w0 = walks_a; dn0 = done_cnt_a; rb0 = rdy_busy_a;
        run_seed(1'b0, 32'd0, 1'b0, cyc);
        checks++;
        if (done_cnt_a != dn0) begin
            fails++; $display("FAIL stream_no_early_done: got %0d pulses required 0", done_cnt_a - dn0);
        end
        wr0 = wr_cnt_a;
        run_seed(1'b0, 32'd200, 1'b0, cyc);
        checks++;
        if (wr_cnt_a != wr0 || busy_a !== 1'b0 || int'(walks_a) - w0 != 4) begin
            fails++; $display("FAIL stream_drop: writes+%0d busy=%b walks+%0d required 0 0 4",
                              wr_cnt_a - wr0, busy_a, int'(walks_a) - w0);
        end
        run_seed(1'b0, 32'd1, 1'b1, cyc);
        @(posedge clk); #1;
        checks++;
        if (done_cnt_a - dn0 != 1) begin
            fails++; $display("FAIL stream_done_count: got %0d required 1", done_cnt_a - dn0);
        end
        checks++;
        if (rdy_busy_a != rb0) begin
            fails++; $display("FAIL stream_ready_busy: ready high while busy %0d times required 0",
                              rdy_busy_a - rb0);
        end
        checks++;
        if (int'(walks_a) - w0 != 8) begin
            fails++; $display("FAIL stream_walks: got +%0d required +8", int'(walks_a) - w0);
        end
        check_ring("stream_seed0");
        // Seed 1: [2][0]=1006, [0][1]=1001, [1][2]=1005
        checks++;
        if (mem_a[1006] !== 32'd4 || mem_a[1001] !== 32'd4 || mem_a[1005] !== 32'd4) begin
            fails++; $display("FAIL stream_seed1: [2][0]=%0d [0][1]=%0d [1][2]=%0d required 4 4 4",
                              mem_a[1006], mem_a[1001], mem_a[1005]);
        end
    endtask

    task automatic test_star();
        int cyc, sum, bad;
        run_seed(1'b1, 32'd0, 1'b1, cyc);
        sum = 0; bad = 0;
        for (int unsigned n = 1; n <= 4; n++) begin
            sum += int'(mem_b[1000 + n]);
            if (mem_b[1000 + n] < 32'd190 || mem_b[1000 + n] > 32'd310) bad++;
        end
        checks++;
        if (sum != 1000) begin
            fails++; $display("FAIL star_sum: got %0d required 1000", sum);
        end
        checks++;
        if (bad != 0) begin
            fails++; $display("FAIL star_spread: counts %0d %0d %0d %0d required each 190..310",
                              mem_b[1001], mem_b[1002], mem_b[1003], mem_b[1004]);
        end
        checks++;
        if (walks_b !== 32'd1000 || dead_b !== 32'd0) begin
            fails++; $display("FAIL star_stats: walks=%0d dead=%0d required 1000 0", walks_b, dead_b);
        end
    endtask

    initial begin
        checks = 0; fails = 0;
        done_cnt_a = 0; wr_cnt_a = 0; rdy_busy_a = 0;
        valid_a = 1'b0; last_a = 1'b0; node_a = '0;
        valid_b = 1'b0; last_b = 1'b0; node_b = '0;
        ld_we_a = 1'b0; ld_we_b = 1'b0; ld_addr = '0; ld_data = '0;
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        @(posedge clk); #1;
        test_reset();
        load_graphs();
        test_ring();
        test_dead_end();
        test_saturation();
        test_reset_mid();
        test_seed_stream();
        test_star();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
